// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: write port, read port, clear, output mask and status.
// The master drives the strobes and operands; the slave returns read data and entry status.
interface param_register_file_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [WIDTH-1:0]  WrData;
  logic [1:0]        WrMode;
  logic              RdEn;
  logic [ADDR_W-1:0] RdAddr;
  logic              OutEn;
  logic              ClrEn;
  logic [WIDTH-1:0]  RdData;
  logic              RdValid;
  logic [DEPTH-1:0]  EntryValid;

  modport master (
    output WrEn, WrAddr, WrData, WrMode, RdEn, RdAddr, OutEn, ClrEn,
    input  RdData, RdValid, EntryValid
  );

  modport slave (
    input  WrEn, WrAddr, WrData, WrMode, RdEn, RdAddr, OutEn, ClrEn,
    output RdData, RdValid, EntryValid
  );
endinterface

// File: rtl/param_register_file.sv
// Register file with read-modify-write write port, registered read port with
// same-cycle write bypass, bulk clear, per-entry valid flags and an output mask.
module param_register_file #(
  parameter int               WIDTH     = 8,
  parameter int               ADDR_W    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                    Clock,
  input logic                    Reset,
  param_register_file_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  function automatic logic [WIDTH-1:0] rmw(input logic [WIDTH-1:0] old_val,
                                           input logic [WIDTH-1:0] operand,
                                           input logic [1:0]       mode);
    logic [WIDTH-1:0] res;
    case (mode)
      2'b00:   res = operand;
      2'b01:   res = old_val & operand;
      2'b10:   res = old_val | operand;
      default: res = old_val ^ operand;
    endcase
    return res;
  endfunction

  logic [DEPTH-1:0][WIDTH-1:0] entries;
  logic [WIDTH-1:0]            wr_result;
  logic                        write_ok;

  // Clear has priority over a write issued in the same cycle.
  assign write_ok  = bus.WrEn && !bus.ClrEn;
  assign wr_result = rmw(entries[bus.WrAddr], bus.WrData, bus.WrMode);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_q;
    logic [WIDTH-1:0] entry_d;

    always_comb begin
      entry_d = entry_q;
      if (bus.ClrEn) begin
        entry_d = RESET_VAL;
      end else if (write_ok && (bus.WrAddr == ADDR_W'(gi))) begin
        entry_d = wr_result;
      end
    end

    always_ff @(posedge Clock) begin
      if (Reset) begin
        entry_q <= RESET_VAL;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign entries[gi] = entry_q;
  end

  logic [WIDTH-1:0] rd_q, rd_d;
  logic             rd_valid_q, rd_valid_d;
  logic [DEPTH-1:0] entry_valid_q, entry_valid_d;
  logic [WIDTH-1:0] rd_source;

  // The read observes the entry as it will be after this edge's update.
  always_comb begin
    rd_source = entries[bus.RdAddr];
    if (bus.ClrEn) begin
      rd_source = RESET_VAL;
    end else if (write_ok && (bus.WrAddr == bus.RdAddr)) begin
      rd_source = wr_result;
    end
  end

  always_comb begin
    rd_d          = rd_q;
    rd_valid_d    = 1'b0;
    entry_valid_d = entry_valid_q;
    if (bus.RdEn) begin
      rd_d       = rd_source;
      rd_valid_d = 1'b1;
    end
    if (bus.ClrEn) begin
      entry_valid_d = '0;
    end else if (write_ok) begin
      entry_valid_d[bus.WrAddr] = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_q          <= '0;
      rd_valid_q    <= 1'b0;
      entry_valid_q <= '0;
    end else begin
      rd_q          <= rd_d;
      rd_valid_q    <= rd_valid_d;
      entry_valid_q <= entry_valid_d;
    end
  end

  assign bus.RdData     = bus.OutEn ? rd_q : '0;
  assign bus.RdValid    = rd_valid_q;
  assign bus.EntryValid = entry_valid_q;
endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised register file: the multi-entry successor to the single 8-bit data register.
- One write port with read-modify-write modes, one registered read port with a same-cycle write bypass, bulk clear, per-entry valid flags and an output-enable mask.
- Sits between the ALU result bus and the filter datapath as operand/result storage.

Parameters:
WIDTH, 8, data width of each entry in bits
ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries (derived, not overridable)
RESET_VAL, 0, value loaded into every entry on Reset or ClrEn (WIDTH bits)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
WrEn  input  1  write strobe, active-high
WrAddr  input  ADDR_W  write entry index
WrData  input  WIDTH  write operand
WrMode  input  2  00 load, 01 AND, 10 OR, 11 XOR (entry op WrData)
RdEn  input  1  read strobe, active-high
RdAddr  input  ADDR_W  read entry index
OutEn  input  1  output enable, active-high; low masks RdData to 0
ClrEn  input  1  bulk clear of all entries, active-high
RdData  output  WIDTH  registered read data (masked by OutEn)
RdValid  output  1  one-cycle pulse: RdData updated this cycle
EntryValid  output  DEPTH  bit i set when entry i was written since last Reset/ClrEn

Behaviour:
- All state changes on the rising edge of Clock; no asynchronous paths except the OutEn mask.
- Reset (sync, active-high), highest priority:
  - all entries <= RESET_VAL
  - internal read register <= 0, RdValid <= 0, EntryValid <= 0
  - WrEn, RdEn and ClrEn are ignored that cycle.
- Write, when WrEn=1 and ClrEn=0:
  - entry[WrAddr] <= f(entry[WrAddr], WrData, WrMode)
  - f: load = WrData; AND/OR/XOR = bitwise, full WIDTH, no carry
  - EntryValid[WrAddr] <= 1.
- Clear, when ClrEn=1 and Reset=0:
  - all entries <= RESET_VAL, EntryValid <= 0
  - a simultaneous WrEn is dropped (clear wins).
- Read:
  - RdEn=1 at edge N: internal read register gets the entry value; RdValid=1 during cycle N+1 only.
  - Read latency is exactly 1 cycle.
  - RdEn=0: read register holds its last value, RdValid=0.
- Bypass, when RdEn=1 and WrEn=1 with RdAddr==WrAddr in the same cycle:
  - read returns the post-write value f(old, WrData, WrMode), never the stale value.
- Read during clear (RdEn=1 and ClrEn=1): read returns RESET_VAL, RdValid=1.
- Reads of never-written entries are legal and return RESET_VAL; EntryValid tells software the entry is uninitialised.
- Read and write to different addresses in the same cycle are independent and both complete.
- Output mask:
  - RdData = OutEn ? read register : 0 (combinational AND; never X or Z)
  - OutEn does not affect RdValid or internal state.
- Reset asserted mid-sequence: a pending RdValid pulse is cancelled the next cycle, and the RMW in that cycle is discarded.
- Full address range is valid; no out-of-range condition exists.

Test Plan:
- Reset then RdEn at RdAddr=2 (WIDTH=8, RESET_VAL=0) -> next cycle RdData=0x00, RdValid=1, EntryValid=4'b0000.
- Write load 0xA5 to entry 1; read entry 1 next cycle -> RdData=0xA5 one cycle after RdEn, EntryValid=4'b0010.
- Entry 3=0xF0; same-cycle WrEn XOR 0xFF to 3 with RdEn RdAddr=3 -> RdData=0x0F (bypass), entry 3 holds 0x0F.
- Entries 0 and 2 written 0x11, 0x22; assert ClrEn together with WrEn load 0x33 to entry 0 -> all entries 0x00, EntryValid=0, subsequent read of 0 returns 0x00.
- Entry 0=0x3C, read with OutEn=0 -> RdData=0x00, RdValid=1; raise OutEn next cycle without a new read -> RdData=0x3C, RdValid=0.
- Sequence AND 0x0F then OR 0x80 on entry 2 preloaded 0x5A -> entry 2 = 0x8A; Reset asserted during the OR cycle -> entry 2 = 0x00, RdValid=0.
